// File: rtl/div_pkg.sv
// Shared divider definitions: ALU opcodes, FSM states and FIX-stage result tags.
package div_pkg;

  localparam logic [4:0] ALU_DIVU = 5'b00110;
  localparam logic [4:0] ALU_DIVS = 5'b00111;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Selects how the FIX stage builds the registered result.
  typedef enum logic [1:0] {
    NORMAL,
    DIV0,
    INVALID
  } fix_tag_t;

endpackage

// File: rtl/seq_array_divider_if.sv
// Start/busy/done handshake and result bus of the sequential divider.
interface seq_array_divider_if #(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
);

  logic             start;
  logic [4:0]       aluop;
  logic [DVD_W-1:0] dividend;
  logic [DVS_W-1:0] divisor;
  logic             busy;
  logic             done;
  logic [DVD_W-1:0] quotient;
  logic [DVS_W-1:0] remainder;
  logic             ZF;
  logic             NF;
  logic             OF;

  modport master (
    output start, aluop, dividend, divisor,
    input  busy, done, quotient, remainder, ZF, NF, OF
  );

  modport slave (
    input  start, aluop, dividend, divisor,
    output busy, done, quotient, remainder, ZF, NF, OF
  );

endinterface

// File: rtl/div_abs.sv
// Conditional two's-complement negate, truncated to W bits. Used both to take
// operand magnitudes and to restore the sign of quotient/remainder.
module div_abs #(
  parameter int W = 8
) (
  input  logic [W-1:0] value,
  input  logic         neg,
  output logic [W-1:0] result
);

  // Negate when requested; the most negative value maps onto itself.
  always_comb begin
    result = neg ? (~value) + W'(1) : value;
  end

endmodule

// File: rtl/seq_array_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, DIVU/DIVS.
// Optional build macro SEQ_DIV_EARLY_EXIT_EN: skip the iteration phase when
// |dividend| < |divisor|; results are identical, only latency changes.
module seq_array_divider
  import div_pkg::*;
#(
  parameter int DVD_W = 16,
  parameter int DVS_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  seq_array_divider_if.slave bus
);

  localparam int CNT_W = $clog2(DVD_W + 1);
  localparam logic [DVD_W-1:0] DVD_MIN = {1'b1, {(DVD_W-1){1'b0}}};

  state_t           state_q, state_d;
  fix_tag_t         tag_q, accept_tag;
  logic             div_s_q, sign_dvd_q, sign_dvs_q, ovf_q;
  logic [DVD_W-1:0] dvd_sr_q, quo_sr_q;
  logic [DVS_W-1:0] abs_dvs_q, rem_q;
  logic [CNT_W-1:0] cnt_q;

  logic             busy, done;
  logic [DVD_W-1:0] quotient_q;
  logic [DVS_W-1:0] remainder_q;
  logic             zf_q, nf_q, of_q;

  // Accept-time decode of the incoming request.
  logic             accept, op_valid, op_signed, dvs_zero, in_ovf, early;
  logic             in_sign_dvd, in_sign_dvs;
  logic [DVD_W-1:0] in_abs_dvd;
  logic [DVS_W-1:0] in_abs_dvs;

  assign accept      = (state_q == IDLE) && bus.start;
  assign op_signed   = (bus.aluop == ALU_DIVS);
  assign op_valid    = (bus.aluop == ALU_DIVU) || op_signed;
  assign in_sign_dvd = op_signed && bus.dividend[DVD_W-1];
  assign in_sign_dvs = op_signed && bus.divisor[DVS_W-1];
  assign dvs_zero    = (bus.divisor == '0);
  assign in_ovf      = op_signed && (bus.dividend == DVD_MIN) && (&bus.divisor);
  assign accept_tag  = !op_valid ? INVALID : (dvs_zero ? DIV0 : NORMAL);

  div_abs #(.W(DVD_W)) u_abs_dvd (.value(bus.dividend), .neg(in_sign_dvd), .result(in_abs_dvd));
  div_abs #(.W(DVS_W)) u_abs_dvs (.value(bus.divisor),  .neg(in_sign_dvs), .result(in_abs_dvs));

`ifdef SEQ_DIV_EARLY_EXIT_EN
  assign early = op_valid && !dvs_zero && (in_abs_dvd < DVD_W'(in_abs_dvs));
`else
  assign early = 1'b0;
`endif

  // One restoring step: rem_shift is the DVS_W+1-bit partial remainder. If its
  // top bit is set it already exceeds any divisor, and the true difference
  // always fits in DVS_W bits, so the low bits of the subtraction suffice.
  logic [DVS_W:0]   rem_shift;
  logic             rem_ge;
  logic [DVS_W-1:0] rem_step;

  assign rem_shift = {rem_q, dvd_sr_q[DVD_W-1]};
  assign rem_ge    = rem_shift[DVS_W] || (rem_shift[DVS_W-1:0] >= abs_dvs_q);
  assign rem_step  = rem_ge ? rem_shift[DVS_W-1:0] - abs_dvs_q : rem_shift[DVS_W-1:0];

  // Sign restore of the unsigned result (signs are 0 for DIVU).
  logic [DVD_W-1:0] q_fix;
  logic [DVS_W-1:0] r_fix;

  div_abs #(.W(DVD_W)) u_fix_q (.value(quo_sr_q), .neg(sign_dvd_q ^ sign_dvs_q), .result(q_fix));
  div_abs #(.W(DVS_W)) u_fix_r (.value(rem_q),    .neg(sign_dvd_q),              .result(r_fix));

  // State register.
  // NOTE: every clocked block uses non-blocking (<=) so all registers update
  // together from values sampled at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = ((accept_tag != NORMAL) || early) ? FIX : CALC;
      CALC: if (cnt_q == '0) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state_q == CALC) || (state_q == FIX);
    done = (state_q == DONE);
  end

  // Working registers: operand capture on accept, one iteration per CALC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q      <= NORMAL;
      div_s_q    <= 1'b0;
      sign_dvd_q <= 1'b0;
      sign_dvs_q <= 1'b0;
      ovf_q      <= 1'b0;
      dvd_sr_q   <= '0;
      abs_dvs_q  <= '0;
      quo_sr_q   <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          tag_q      <= accept_tag;
          div_s_q    <= op_signed;
          sign_dvd_q <= in_sign_dvd;
          sign_dvs_q <= in_sign_dvs;
          ovf_q      <= in_ovf;
          dvd_sr_q   <= in_abs_dvd;
          abs_dvs_q  <= in_abs_dvs;
          quo_sr_q   <= '0;
          cnt_q      <= CNT_W'(DVD_W - 1);
          // The remainder register doubles as the carrier for the raw
          // dividend bits on divide-by-zero and for the early-exit result.
          if (accept_tag == DIV0) rem_q <= bus.dividend[DVS_W-1:0];
          else if (early)         rem_q <= in_abs_dvd[DVS_W-1:0];
          else                    rem_q <= '0;
        end
        CALC: begin
          rem_q    <= rem_step;
          quo_sr_q <= {quo_sr_q[DVD_W-2:0], rem_ge};
          dvd_sr_q <= {dvd_sr_q[DVD_W-2:0], 1'b0};
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Result registers: written only in FIX, held until the next FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      zf_q        <= 1'b0;
      nf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else if (state_q == FIX) begin
      case (tag_q)
        NORMAL: begin
          quotient_q  <= q_fix;
          remainder_q <= r_fix;
          zf_q        <= (q_fix == '0);
          nf_q        <= div_s_q && q_fix[DVD_W-1];
          of_q        <= ovf_q;
        end
        DIV0: begin
          quotient_q  <= '1;
          remainder_q <= rem_q;
          zf_q        <= 1'b1;
          nf_q        <= 1'b0;
          of_q        <= 1'b0;
        end
        default: begin
          quotient_q  <= '0;
          remainder_q <= '0;
          zf_q        <= 1'b1;
          nf_q        <= 1'b0;
          of_q        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.ZF        = zf_q;
  assign bus.NF        = nf_q;
  assign bus.OF        = of_q;

endmodule

// File: tb/tb_seq_array_divider.sv
// Self-checking bench for seq_array_divider: directed table, handshake
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_array_divider;
  import div_pkg::*;

  localparam int DW = 16;
  localparam int SW = 8;
  localparam int LAT_FULL  = DW + 2;
  localparam int LAT_SHORT = 2;
`ifdef SEQ_DIV_EARLY_EXIT_EN
  localparam int LAT_EE = LAT_SHORT;
`else
  localparam int LAT_EE = LAT_FULL;
`endif

  typedef struct {
    logic [DW-1:0] q;
    logic [SW-1:0] r;
    logic          zf;
    logic          nf;
    logic          of;
    int            lat;
  } res_t;

  typedef struct {
    logic [4:0]    op;
    logic [DW-1:0] a;
    logic [SW-1:0] b;
    res_t          exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_array_divider_if #(.DVD_W(DW), .DVS_W(SW)) bus ();
  seq_array_divider #(.DVD_W(DW), .DVS_W(SW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero.
  function automatic void model(input logic [4:0] op, input logic [DW-1:0] a,
                                input logic [SW-1:0] b, output res_t e);
    int          sa, sb, qi, ri, mag_a, mag_b;
    int unsigned ua, ub;
    e = '{q: '0, r: '0, zf: 1'b1, nf: 1'b0, of: 1'b0, lat: LAT_SHORT};
    if (op != ALU_DIVU && op != ALU_DIVS) return;
    if (b == 0) begin
      e.q = '1;
      e.r = a[SW-1:0];
      return;
    end
    if (op == ALU_DIVU) begin
      ua = a; ub = b;
      qi = int'(ua / ub); ri = int'(ua % ub);
      mag_a = int'(ua); mag_b = int'(ub);
    end else begin
      sa = $signed(a); sb = $signed(b);
      mag_a = (sa < 0) ? -sa : sa;
      mag_b = (sb < 0) ? -sb : sb;
      if (sa == -(1 << (DW - 1)) && sb == -1) begin
        qi = sa; ri = 0; e.of = 1'b1;
      end else begin
        qi = sa / sb; ri = sa % sb;
      end
    end
    e.q   = qi[DW-1:0];
    e.r   = ri[SW-1:0];
    e.zf  = (e.q == 0);
    e.nf  = (op == ALU_DIVS) && e.q[DW-1];
    e.lat = (mag_a < mag_b) ? LAT_EE : LAT_FULL;
  endfunction

  // Issue one operation, watch busy/done, compare the result and the hold.
  task automatic run_op(input string name, input logic [4:0] op, input logic [DW-1:0] a,
                        input logic [SW-1:0] b, input int inject_at, input res_t e);
    int   cyc;
    bit   seen, busy_ok;
    res_t got;
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = op; bus.dividend = a; bus.divisor = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.aluop = 5'($urandom); bus.dividend = DW'($urandom); bus.divisor = SW'($urandom);
    cyc = 0; seen = 1'b0; busy_ok = 1'b1;
    got = '{q: '0, r: '0, zf: 1'b0, nf: 1'b0, of: 1'b0, lat: 0};
    while (!seen && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (bus.done) begin
        seen = 1'b1;
        got = '{q: bus.quotient, r: bus.remainder, zf: bus.ZF, nf: bus.NF, of: bus.OF, lat: cyc};
        check({name, ".busy_at_done"}, 32'(bus.busy), 32'd0);
      end else if (!bus.busy) begin
        busy_ok = 1'b0;
      end
      if (cyc == inject_at) begin
        bus.start = 1'b1; bus.aluop = ALU_DIVU; bus.dividend = 16'd50; bus.divisor = 8'd3;
      end else if (cyc == inject_at + 1) begin
        bus.start = 1'b0;
      end
    end
    check({name, ".done_seen"}, 32'(seen), 32'd1);
    check({name, ".latency"}, got.lat, e.lat);
    check({name, ".busy"}, 32'(busy_ok), 32'd1);
    check({name, ".q"}, 32'(got.q), 32'(e.q));
    check({name, ".r"}, 32'(got.r), 32'(e.r));
    check({name, ".flags"}, {29'd0, got.zf, got.nf, got.of}, {29'd0, e.zf, e.nf, e.of});
    @(negedge clk);
    check({name, ".done_pulse"}, 32'(bus.done), 32'd0);
    check({name, ".hold"}, {bus.quotient, 8'd0, bus.remainder}, {e.q, 8'd0, e.r});
  endtask

  initial begin
    vec_t vecs[14];
    res_t e;
    int   done_cnt, first_done, second_done;

    bus.start = 1'b0; bus.aluop = '0; bus.dividend = '0; bus.divisor = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.q", 32'(bus.quotient), 32'd0);
    check("reset.r", 32'(bus.remainder), 32'd0);
    check("reset.flags", {29'd0, bus.ZF, bus.NF, bus.OF}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table with hand-derived expectations.
    vecs[0]  = '{ALU_DIVU, 16'd1000, 8'd7,   '{16'd142,  8'h06, 1'b0, 1'b0, 1'b0, LAT_FULL}};
    vecs[1]  = '{ALU_DIVS, 16'hFF9C, 8'd7,   '{16'hFFF2, 8'hFE, 1'b0, 1'b1, 1'b0, LAT_FULL}};
    vecs[2]  = '{ALU_DIVS, 16'h8000, 8'hFF,  '{16'h8000, 8'h00, 1'b0, 1'b1, 1'b1, LAT_FULL}};
    vecs[3]  = '{ALU_DIVU, 16'h1234, 8'h00,  '{16'hFFFF, 8'h34, 1'b1, 1'b0, 1'b0, LAT_SHORT}};
    vecs[4]  = '{5'b00000, 16'h1234, 8'd5,   '{16'h0000, 8'h00, 1'b1, 1'b0, 1'b0, LAT_SHORT}};
    vecs[5]  = '{ALU_DIVU, 16'd5,    8'd9,   '{16'h0000, 8'h05, 1'b1, 1'b0, 1'b0, LAT_EE}};
    vecs[6]  = '{ALU_DIVS, 16'h0064, 8'hF9,  '{16'hFFF2, 8'h02, 1'b0, 1'b1, 1'b0, LAT_FULL}};
    vecs[7]  = '{ALU_DIVU, 16'hFFFF, 8'hFF,  '{16'h0101, 8'h00, 1'b0, 1'b0, 1'b0, LAT_FULL}};
    vecs[8]  = '{ALU_DIVS, 16'hFFF9, 8'h02,  '{16'hFFFD, 8'hFF, 1'b0, 1'b1, 1'b0, LAT_FULL}};
    vecs[9]  = '{ALU_DIVS, 16'h8000, 8'h80,  '{16'h0100, 8'h00, 1'b0, 1'b0, 1'b0, LAT_FULL}};
    vecs[10] = '{ALU_DIVS, 16'hFFFB, 8'h09,  '{16'h0000, 8'hFB, 1'b1, 1'b0, 1'b0, LAT_EE}};
    vecs[11] = '{ALU_DIVU, 16'h8000, 8'hFF,  '{16'h0080, 8'h80, 1'b0, 1'b0, 1'b0, LAT_FULL}};
    vecs[12] = '{ALU_DIVS, 16'h7FFF, 8'hFF,  '{16'h8001, 8'h00, 1'b0, 1'b1, 1'b0, LAT_FULL}};
    vecs[13] = '{ALU_DIVS, 16'h1234, 8'h00,  '{16'hFFFF, 8'h34, 1'b1, 1'b0, 1'b0, LAT_SHORT}};
    for (int i = 0; i < 14; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, vecs[i].exp);

    // A start arriving mid-operation is dropped, not queued.
    run_op("ignored_start", ALU_DIVU, 16'd1000, 8'd7, 5, vecs[0].exp);
    done_cnt = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("ignored_start.extra_done", done_cnt, 0);

    // start held high: re-accepted on the first IDLE cycle after DONE.
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = ALU_DIVU; bus.dividend = 16'd1000; bus.divisor = 8'd7;
    @(posedge clk);
    done_cnt = 0; first_done = 0; second_done = 0;
    for (int c = 1; c <= 2 * LAT_FULL + 2; c++) begin
      @(negedge clk);
      if (bus.done) begin
        done_cnt++;
        if (done_cnt == 1) first_done = c;
        else if (done_cnt == 2) second_done = c;
      end
      if (c == 2 * LAT_FULL + 2) bus.start = 1'b0;
    end
    check("held_start.count", done_cnt, 2);
    check("held_start.first", first_done, LAT_FULL);
    check("held_start.second", second_done, 2 * LAT_FULL + 1);
    check("held_start.q", 32'(bus.quotient), 32'd142);
    repeat (3) @(negedge clk);
    check("held_start.idle", 32'(bus.busy), 32'd0);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    bus.start = 1'b1; bus.aluop = ALU_DIVS; bus.dividend = 16'hFF9C; bus.divisor = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_reset.busy", 32'(bus.busy), 32'd0);
    check("mid_reset.q", 32'(bus.quotient), 32'd0);
    check("mid_reset.r", 32'(bus.remainder), 32'd0);
    check("mid_reset.flags", {29'd0, bus.ZF, bus.NF, bus.OF}, 32'd0);
    done_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.done) done_cnt++;
    end
    check("mid_reset.no_done", done_cnt, 0);
    run_op("after_reset", ALU_DIVS, 16'hFF9C, 8'd7, 0, vecs[1].exp);

    // Randomized operations against the reference model.
    for (int i = 0; i < 150; i++) begin
      logic [4:0]    op;
      logic [DW-1:0] a;
      logic [SW-1:0] b;
      int            sel;
      sel = int'($urandom_range(0, 9));
      op  = (sel < 4) ? ALU_DIVU : (sel < 8) ? ALU_DIVS : 5'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 16'h8000;
        1:       a = DW'($urandom_range(0, 20));
        default: a = DW'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       b = '0;
        1:       b = '1;
        2:       b = SW'($urandom_range(1, 12));
        default: b = SW'($urandom);
      endcase
      if (op != ALU_DIVU && op != ALU_DIVS && b == 0) b = 8'd1;
      model(op, a, b, e);
      run_op($sformatf("rnd%0d", i), op, a, b, 0, e);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
